// File: rtl/mac_pkg.sv
// Shared types and saturation limits for the multiply-accumulate processing element.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  localparam int MAX_ACC_W = 64;

  // Limits are built in a wide word; callers cast down to their own ACC_W.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w, input int sgn);
    logic [MAX_ACC_W-1:0] ones;
    ones = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - acc_w);
    return (sgn != 0) ? (ones >> 1) : ones;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w, input int sgn);
    logic [MAX_ACC_W-1:0] ones;
    ones = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - acc_w);
    return (sgn != 0) ? (ones ^ (ones >> 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder with overflow detection and optional clamping.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED));

  logic [ACC_W:0] raw;
  assign raw = {1'b0, a} + {1'b0, b};

  always_comb begin
    ovf = 1'b0;
    sum = raw[ACC_W-1:0];
    if (SIGNED != 0) ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    else             ovf = raw[ACC_W];
    // A signed overflow always goes toward the sign both operands share.
    if (SATURATE != 0 && ovf)
      sum = (SIGNED != 0 && a[ACC_W-1]) ? SAT_MIN : SAT_MAX;
  end

endmodule

// File: rtl/mac_pe.sv
// Systolic multiply-accumulate element: forwards operands, accumulates len products,
// then holds the result until it is taken.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 8,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int STAGES = 1;
  localparam int PROD_W = 2 * DATA_W;

  state_e              state, state_nxt;
  logic [LEN_W:0]      cnt, len_q, len_eff;
  logic                dcnt;
  logic [STAGES:0]     vld_pipe, first_pipe;
  logic [PROD_W-1:0]   prod, mul;
  logic [ACC_W-1:0]    acc, prod_ext, sum;
  logic                add_ovf, ovf_q;
  logic                accept, first, last_beat;

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign busy      = (state != IDLE);
  assign acc_valid = (state == HOLD);
  assign fwd_valid = vld_pipe[0];
  assign acc_out   = acc;
  assign overflow  = ovf_q;

  // A beat arriving alongside clear is dropped.
  assign accept    = in_valid && in_ready && !clear;
  assign first     = accept && (state == IDLE);
  assign len_eff   = (len == '0) ? (LEN_W+1)'(1) : {1'b0, len};
  assign last_beat = accept && ((state == IDLE) ? (len_eff == (LEN_W+1)'(1))
                                                : ((cnt + 1'b1) == len_q));

  generate
    if (SIGNED != 0) begin : g_signed
      assign mul      = $signed({{DATA_W{a_out[DATA_W-1]}}, a_out}) *
                        $signed({{DATA_W{b_out[DATA_W-1]}}, b_out});
      assign prod_ext = ACC_W'($signed(prod));
    end else begin : g_unsigned
      assign mul      = {{DATA_W{1'b0}}, a_out} * {{DATA_W{1'b0}}, b_out};
      assign prod_ext = ACC_W'(prod);
    end
  endgenerate

  mac_sat_add #(.ACC_W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = last_beat ? DRAIN : ACCUM;
      ACCUM: if (last_beat) state_nxt = DRAIN;
      DRAIN: if (dcnt) state_nxt = HOLD;
      HOLD:  if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out      <= '0;
      b_out      <= '0;
      cnt        <= '0;
      len_q      <= '0;
      dcnt       <= 1'b0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      prod       <= '0;
      acc        <= '0;
      ovf_q      <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      dcnt       <= 1'b0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      acc        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], accept};
      first_pipe <= {first_pipe[STAGES-1:0], first};
      dcnt       <= (state == DRAIN) ? ~dcnt : 1'b0;
      if (accept) begin
        a_out <= a_in;
        b_out <= b_in;
        cnt   <= first ? (LEN_W+1)'(1) : cnt + 1'b1;
      end
      if (first) begin
        len_q <= len_eff;
        acc   <= '0;
        ovf_q <= 1'b0;
      end
      if (vld_pipe[0]) prod <= mul;
      // The first product of a dot product replaces the zeroed accumulator.
      if (vld_pipe[STAGES]) begin
        if (first_pipe[STAGES]) acc <= prod_ext;
        else begin
          acc   <= sum;
          ovf_q <= ovf_q | add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Drives three mac_pe configurations with shared stimulus and checks them against
// an arithmetic dot-product model.
module tb_mac_pe;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, acc_ready;
  logic [7:0] len, a_in, b_in;

  logic       in_ready [3];
  logic [7:0] a_out [3];
  logic [7:0] b_out [3];
  logic       fwd_valid [3];
  logic       acc_valid [3];
  logic       overflow [3];
  logic       busy [3];
  logic [31:0] acc0;
  logic [15:0] acc1, acc2;

  int errs = 0, checks = 0;
  int pa [64];
  int pb [64];
  int n_cur = 0;

  always #5 clk = ~clk;

  mac_pe #(.ACC_W(32), .SIGNED(0), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .len(len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready[0]), .a_out(a_out[0]), .b_out(b_out[0]),
    .fwd_valid(fwd_valid[0]), .acc_out(acc0), .acc_valid(acc_valid[0]),
    .acc_ready(acc_ready), .overflow(overflow[0]), .busy(busy[0]));

  mac_pe #(.ACC_W(16), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .len(len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready[1]), .a_out(a_out[1]), .b_out(b_out[1]),
    .fwd_valid(fwd_valid[1]), .acc_out(acc1), .acc_valid(acc_valid[1]),
    .acc_ready(acc_ready), .overflow(overflow[1]), .busy(busy[1]));

  mac_pe #(.ACC_W(16), .SIGNED(1), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .len(len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready[2]), .a_out(a_out[2]), .b_out(b_out[2]),
    .fwd_valid(fwd_valid[2]), .acc_out(acc2), .acc_valid(acc_valid[2]),
    .acc_ready(acc_ready), .overflow(overflow[2]), .busy(busy[2]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint accv(input int c);
    case (c)
      0:       return longint'(acc0);
      1:       return longint'($signed(acc1));
      default: return longint'($signed(acc2));
    endcase
  endfunction

  // Dot product of pa/pb with per-step wrap or clamp; config 0 unsigned/32,
  // 1 signed/16/saturate, 2 signed/16/wrap.
  function automatic longint model(input int c, input int n, output bit ov);
    bit sg, sat;
    longint m, mx, mn, acc, p, t;
    sg  = (c != 0);
    sat = (c == 1);
    m   = longint'(1) <<< ((c == 0) ? 32 : 16);
    mx  = sg ? m / 2 - 1 : m - 1;
    mn  = sg ? -(m / 2) : 0;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = sg ? longint'(byte'(pa[i])) * longint'(byte'(pb[i]))
             : longint'(pa[i]) * longint'(pb[i]);
      if (i == 0) acc = p;
      else begin
        t = acc + p;
        if (t > mx || t < mn) begin
          ov = 1'b1;
          if (sat) acc = (t > mx) ? mx : mn;
          else begin
            acc = t & (m - 1);
            if (acc > mx) acc -= m;
          end
        end else acc = t;
      end
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    bit     eo;
    longint ev;
    for (int c = 0; c < 3; c++) begin
      ev = model(c, n_cur, eo);
      chk($sformatf("%s acc_out[%0d]", tag, c), accv(c), ev);
      chk($sformatf("%s overflow[%0d]", tag, c), longint'(overflow[c]), longint'(eo));
    end
  endtask

  task automatic run_dot(input int n, input int lenv, input int hold, input string tag);
    n_cur     = n;
    len       = 8'(lenv);
    acc_ready = (hold == 0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a_in     = 8'(pa[i]);
      b_in     = 8'(pb[i]);
      step();
      chk({tag, " fwd_valid"}, longint'(fwd_valid[0]), 1);
      chk({tag, " a_out"}, longint'(a_out[0]), longint'(pa[i]));
      chk({tag, " b_out"}, longint'(b_out[1]), longint'(pb[i]));
    end
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    chk({tag, " in_ready drain"}, longint'(in_ready[0]), 0);
    chk({tag, " acc_valid k"}, longint'(acc_valid[0]), 0);
    step();
    chk({tag, " acc_valid k+1"}, longint'(acc_valid[0]), 0);
    chk({tag, " fwd_valid idle"}, longint'(fwd_valid[0]), 0);
    step();
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s acc_valid k+2 [%0d]", tag, c), longint'(acc_valid[c]), 1);
    check_result(tag);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      step();
      chk({tag, " hold acc_valid"}, longint'(acc_valid[2]), 1);
      chk({tag, " hold in_ready"}, longint'(in_ready[0]), 0);
      chk({tag, " hold fwd_valid"}, longint'(fwd_valid[0]), 0);
      check_result({tag, " hold"});
    end
    in_valid  = 1'b0;
    acc_ready = 1'b1;
    step();
    chk({tag, " post acc_valid"}, longint'(acc_valid[0]), 0);
    chk({tag, " post busy"}, longint'(busy[1]), 0);
    chk({tag, " post in_ready"}, longint'(in_ready[2]), 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; acc_ready = 1'b0;
    len = '0; a_in = 8'hA5; b_in = 8'h5A;
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset acc_out[%0d]", c), accv(c), 0);
      chk($sformatf("reset flags[%0d]", c),
          longint'({acc_valid[c], fwd_valid[c], overflow[c], busy[c]}), 0);
      chk($sformatf("reset a_out[%0d]", c), longint'({a_out[c], b_out[c]}), 0);
    end
    reset = 1'b0;
    step();
    chk("in_ready after reset", longint'(in_ready[0]), 1);
    chk("busy after reset", longint'(busy[0]), 0);

    // Basic unsigned dot product.
    pa[0] = 3;  pb[0] = 5;  pa[1] = 2; pb[1] = 7;
    pa[2] = 10; pb[2] = 10; pa[3] = 1; pb[3] = 1;
    run_dot(4, 4, 0, "basic4");
    chk("basic4 literal", accv(0), 130);

    // Signed extremes: (-128,-128),(-1,127).
    pa[0] = 8'h80; pb[0] = 8'h80; pa[1] = 8'hFF; pb[1] = 8'h7F;
    run_dot(2, 2, 0, "signed2");

    // Overflow on the third add: clamp vs wrap.
    for (int i = 0; i < 3; i++) begin pa[i] = 127; pb[i] = 127; end
    run_dot(3, 3, 0, "ovf3");

    // Long hold in HOLD with junk inputs, then a fresh single-product run.
    for (int i = 0; i < 3; i++) begin pa[i] = int'($urandom_range(0, 255)); pb[i] = int'($urandom_range(0, 255)); end
    run_dot(3, 3, 10, "hold10");
    pa[0] = 9; pb[0] = 8'hF3;
    run_dot(1, 1, 0, "after_hold");

    // len=0 behaves as a single product.
    pa[0] = 8'hC4; pb[0] = 8'h1D;
    run_dot(1, 0, 0, "len0");

    // clear after 2 of 4 beats; the beat under clear is dropped.
    for (int i = 0; i < 4; i++) begin pa[i] = int'($urandom_range(1, 255)); pb[i] = int'($urandom_range(1, 255)); end
    len = 8'd4; acc_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a_in = 8'(pa[i]); b_in = 8'(pb[i]);
      step();
    end
    clear = 1'b1; in_valid = 1'b1; a_in = 8'(pa[2]); b_in = 8'(pb[2]);
    step();
    clear = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("clear acc_out[%0d]", c), accv(c), 0);
      chk($sformatf("clear flags[%0d]", c),
          longint'({acc_valid[c], fwd_valid[c], overflow[c], busy[c]}), 0);
    end
    chk("clear a_out hold", longint'(a_out[0]), longint'(pa[1]));
    chk("clear in_ready", longint'(in_ready[0]), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clear no acc_valid", longint'(acc_valid[0]), 0);
    end
    pa[0] = 6; pb[0] = 7;
    run_dot(1, 1, 0, "after_clear");
    chk("after_clear literal", accv(0), 42);

    // reset during DRAIN abandons the result.
    pa[0] = 8'h33; pb[0] = 8'h44; pa[1] = 8'h55; pb[1] = 8'h66;
    len = 8'd2; acc_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a_in = 8'(pa[i]); b_in = 8'(pb[i]);
      step();
    end
    in_valid = 1'b0;
    chk("drain busy", longint'(busy[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mid reset acc_out[%0d]", c), accv(c), 0);
      chk($sformatf("mid reset flags[%0d]", c),
          longint'({acc_valid[c], fwd_valid[c], overflow[c], busy[c]}), 0);
      chk($sformatf("mid reset a_out[%0d]", c), longint'({a_out[c], b_out[c]}), 0);
      chk($sformatf("mid reset in_ready[%0d]", c), longint'(in_ready[c]), 1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("aborted no acc_valid", longint'(acc_valid[0] | acc_valid[1]), 0);
    end

    // Randomized dot products with random result back-pressure.
    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        pa[i] = int'($urandom_range(0, 255));
        pb[i] = int'($urandom_range(0, 255));
      end
      run_dot(n, n, int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
